// File: rtl/video_driver_pkg.sv
// rtl/video_driver_pkg.sv - 720p timing defaults, RGB565 colour constants and range helper
package video_driver_pkg;

  localparam int H_SYNC_720P  = 40;
  localparam int H_BACK_720P  = 220;
  localparam int H_DISP_720P  = 1280;
  localparam int H_FRONT_720P = 110;
  localparam int H_TOTAL_720P = H_SYNC_720P + H_BACK_720P + H_DISP_720P + H_FRONT_720P;

  localparam int V_SYNC_720P  = 5;
  localparam int V_BACK_720P  = 20;
  localparam int V_DISP_720P  = 720;
  localparam int V_FRONT_720P = 5;
  localparam int V_TOTAL_720P = V_SYNC_720P + V_BACK_720P + V_DISP_720P + V_FRONT_720P;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

  // Half-open window test: lo <= x < hi
  function automatic logic in_range(input logic [11:0] x, input logic [11:0] lo,
                                    input logic [11:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/video_driver.sv
// rtl/video_driver.sv - raster timing generator: one counter pair, registered sync/enable/position decode
module video_driver
  import video_driver_pkg::*;
#(
  parameter int   H_SYNC   = H_SYNC_720P,
  parameter int   H_BACK   = H_BACK_720P,
  parameter int   H_DISP   = H_DISP_720P,
  parameter int   H_FRONT  = H_FRONT_720P,
  parameter int   V_SYNC   = V_SYNC_720P,
  parameter int   V_BACK   = V_BACK_720P,
  parameter int   V_DISP   = V_DISP_720P,
  parameter int   V_FRONT  = V_FRONT_720P,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        hdmi_clk,
  input  logic        rst,
  input  logic [15:0] pixel_data,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [15:0] video_rgb,
  output logic        frame_start
);

  localparam logic [11:0] L_H_SYNC = 12'(H_SYNC);
  localparam logic [11:0] L_HA_BEG = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] L_HA_END = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] L_HR_BEG = 12'(H_SYNC + H_BACK - 1);
  localparam logic [11:0] L_HR_END = 12'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [11:0] L_H_LAST = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [11:0] L_V_SYNC = 12'(V_SYNC);
  localparam logic [11:0] L_VA_BEG = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] L_VA_END = 12'(V_SYNC + V_BACK + V_DISP);
  localparam logic [11:0] L_V_LAST = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);

  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic        r_run;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_req;
  logic [10:0] r_xpos;
  logic [10:0] r_ypos;
  logic        r_fs;

  logic [11:0] w_h_nxt;
  logic [11:0] w_v_nxt;
  logic        w_h_wrap;
  logic        w_v_act;
  logic [11:0] w_x;
  logic [11:0] w_y;

  assign w_h_wrap = (r_h_cnt == L_H_LAST);

  // Position (0,0) is held for the first clock after reset so that frame_start fires there
  always_comb begin
    w_h_nxt = '0;
    w_v_nxt = '0;
    if (r_run) begin
      w_h_nxt = w_h_wrap ? 12'd0 : r_h_cnt + 12'd1;
      w_v_nxt = r_v_cnt;
      if (w_h_wrap) begin
        w_v_nxt = (r_v_cnt == L_V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
      end
    end
  end

  assign w_v_act = in_range(w_v_nxt, L_VA_BEG, L_VA_END);
  assign w_x     = w_h_nxt - L_HR_BEG + 12'd1;
  assign w_y     = w_v_nxt - L_VA_BEG + 12'd1;

  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      r_run   <= 1'b0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hs    <= ~SYNC_POL;
      r_vs    <= ~SYNC_POL;
      r_de    <= 1'b0;
      r_req   <= 1'b0;
      r_xpos  <= '0;
      r_ypos  <= '0;
      r_fs    <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_hs    <= (w_h_nxt < L_H_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vs    <= (w_v_nxt < L_V_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_de    <= w_v_act && in_range(w_h_nxt, L_HA_BEG, L_HA_END);
      r_req   <= w_v_act && in_range(w_h_nxt, L_HR_BEG, L_HR_END);
      r_xpos  <= (w_v_act && in_range(w_h_nxt, L_HR_BEG, L_HR_END)) ? w_x[10:0] : 11'd0;
      r_ypos  <= w_v_act ? w_y[10:0] : 11'd0;
      r_fs    <= (w_h_nxt == 12'd0) && (w_v_nxt == 12'd0);
    end
  end

  assign video_hs    = r_hs;
  assign video_vs    = r_vs;
  assign video_de    = r_de;
  assign data_req    = r_req;
  assign pixel_xpos  = r_xpos;
  assign pixel_ypos  = r_ypos;
  assign frame_start = r_fs;
  assign video_rgb   = r_de ? pixel_data : RGB565_BLACK;

endmodule

// File: tb/tb_video_driver.sv
// tb/tb_video_driver.sv - randomized pixel/reset stimulus against a frame-position reference model
module tb_video_driver;

  localparam int HS = 4, HB = 6, HD = 16, HF = 3;
  localparam int VS = 2, VB = 3, VD = 5, VF = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FR = HT * VT;
  localparam logic POL = 1'b0;
  localparam int N_CYC = 1800;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pixel_data;
  logic        data_req;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic        video_hs;
  logic        video_vs;
  logic        video_de;
  logic [15:0] video_rgb;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  video_driver #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .SYNC_POL(POL)
  ) dut (
    .hdmi_clk   (clk),
    .rst        (rst),
    .pixel_data (pixel_data),
    .data_req   (data_req),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .video_hs   (video_hs),
    .video_vs   (video_vs),
    .video_de   (video_de),
    .video_rgb  (video_rgb),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    int t;
    int last_fs;
    int c1;
    int c2;
    int len2;
    int p, h, v;
    bit vact, e_hs, e_vs, e_de, e_req, e_fs;
    int e_x, e_y;

    t       = -1;
    last_fs = -1;
    c1      = 3 + 2 * FR + 6 * HT + 10;
    c2      = c1 + 3 + int'($urandom_range(400, 600));
    len2    = int'($urandom_range(1, 4));
    rst        = 1'b1;
    pixel_data = 16'h0;

    for (int c = 0; c < N_CYC; c++) begin
      rst = (c < 3) || (c >= c1 && c < c1 + 3) || (c >= c2 && c < c2 + len2);
      pixel_data = (c >= 100 && c < 100 + FR) ? 16'hF800 : 16'($urandom);
      @(posedge clk);
      if (rst) t = -1;
      else     t = (t < 0) ? 0 : t + 1;
      #1;

      if (t < 0) begin
        e_hs = ~POL; e_vs = ~POL; e_de = 0; e_req = 0; e_fs = 0; e_x = 0; e_y = 0;
      end else begin
        p    = t % FR;
        h    = p % HT;
        v    = p / HT;
        vact = (v >= VS + VB) && (v < VS + VB + VD);
        e_hs = (h < HS) ? POL : ~POL;
        e_vs = (v < VS) ? POL : ~POL;
        e_de = vact && (h >= HS + HB) && (h < HS + HB + HD);
        e_req = vact && (h >= HS + HB - 1) && (h < HS + HB + HD - 1);
        e_x  = e_req ? h - (HS + HB) + 2 : 0;
        e_y  = vact ? v - (VS + VB) + 1 : 0;
        e_fs = (p == 0);
      end

      chk("hs", 32'(video_hs), 32'(e_hs));
      chk("vs", 32'(video_vs), 32'(e_vs));
      chk("de", 32'(video_de), 32'(e_de));
      chk("req", 32'(data_req), 32'(e_req));
      chk("xpos", 32'(pixel_xpos), 32'(e_x));
      chk("ypos", 32'(pixel_ypos), 32'(e_y));
      chk("fs", 32'(frame_start), 32'(e_fs));
      chk("rgb", 32'(video_rgb), e_de ? 32'(pixel_data) : 32'h0);

      if (t < 0) begin
        last_fs = -1;
      end else if (frame_start === 1'b1) begin
        if (last_fs >= 0) chk("fs_period", 32'(c - last_fs), 32'(FR));
        last_fs = c;
      end

      // video_rgb must follow pixel_data combinationally, not as a captured value
      pixel_data = 16'($urandom);
      #1;
      chk("rgb_comb", 32'(video_rgb), e_de ? 32'(pixel_data) : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
